// File: rtl/ram_master_if.sv
// Command, write-data, read-data and RAM-side signals of the burst RAM master.
// The master modport is the ram_master side; slave is the client/RAM side.
interface ram_master_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_wr;
  logic [N-1:0] cmd_addr;
  logic [N-1:0] cmd_len;
  logic         wd_valid;
  logic         wd_ready;
  logic [W-1:0] wd_data;
  logic         rd_valid;
  logic         rd_ready;
  logic [W-1:0] rd_data;
  logic         rd_last;
  logic         mem_valid;
  logic         mem_wr_rd;
  logic [N-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;
  logic         mem_ready;
  logic         busy;
  logic         done;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wd_valid, wd_data, rd_ready,
           mem_rdata, mem_ready,
    output cmd_ready, wd_ready, rd_valid, rd_data, rd_last, mem_valid,
           mem_wr_rd, mem_addr, mem_wdata, busy, done
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, wd_valid, wd_data, rd_ready,
           mem_rdata, mem_ready,
    input  cmd_ready, wd_ready, rd_valid, rd_data, rd_last, mem_valid,
           mem_wr_rd, mem_addr, mem_wdata, busy, done
  );
endinterface

// File: rtl/ram_master.sv
// Burst RAM master: turns write/read burst commands into single-word RAM
// accesses, one write beat per cycle, reads as request/capture/output beats.
module ram_master #(
  parameter int N = 4,
  parameter int D = 16,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  ram_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_CAP, RD_OUT} state_t;

  localparam logic [N-1:0] LAST_ADDR = N'(D - 1);

  state_t       state, state_nxt;
  logic [N-1:0] addr, addr_nxt, addr_inc;
  logic [N-1:0] cnt, cnt_nxt;
  logic [W-1:0] rd_data_q, rd_data_nxt;
  logic [N-1:0] mem_addr_q, mem_addr_nxt;
  logic [W-1:0] mem_wdata_q, mem_wdata_nxt;
  logic         wr_pulse_q, wr_pulse_nxt;
  logic         done_q, done_nxt;

  assign addr_inc = (addr == LAST_ADDR) ? '0 : addr + N'(1);

  always_ff @(posedge clk) begin
    // NOTE: rst is tested inside the clocked block, so reset is synchronous;
    // state is always updated with <= so every register samples pre-edge values.
    if (!rst) begin
      state       <= IDLE;
      addr        <= '0;
      cnt         <= '0;
      rd_data_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_pulse_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      addr        <= addr_nxt;
      cnt         <= cnt_nxt;
      rd_data_q   <= rd_data_nxt;
      mem_addr_q  <= mem_addr_nxt;
      mem_wdata_q <= mem_wdata_nxt;
      wr_pulse_q  <= wr_pulse_nxt;
      done_q      <= done_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_nxt     = state;
    addr_nxt      = addr;
    cnt_nxt       = cnt;
    rd_data_nxt   = rd_data_q;
    mem_addr_nxt  = mem_addr_q;
    mem_wdata_nxt = mem_wdata_q;
    wr_pulse_nxt  = 1'b0;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_nxt     = bus.cmd_addr;
          cnt_nxt      = bus.cmd_len;
          mem_addr_nxt = bus.cmd_addr;
          state_nxt    = bus.cmd_wr ? WR : RD_REQ;
        end
      end
      WR: begin
        // A beat becomes a one-cycle RAM write strobe in the following cycle.
        if (bus.wd_valid) begin
          wr_pulse_nxt  = 1'b1;
          mem_addr_nxt  = addr;
          mem_wdata_nxt = bus.wd_data;
          addr_nxt      = addr_inc;
          cnt_nxt       = cnt - N'(1);
          if (cnt == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      RD_REQ: state_nxt = RD_CAP;
      RD_CAP: begin
        if (bus.mem_ready) begin
          rd_data_nxt = bus.mem_rdata;
          state_nxt   = RD_OUT;
        end
      end
      RD_OUT: begin
        if (bus.rd_ready) begin
          if (cnt == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            addr_nxt     = addr_inc;
            cnt_nxt      = cnt - N'(1);
            mem_addr_nxt = addr_inc;
            state_nxt    = RD_REQ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cmd_ready is gated by rst so it stays low for the whole reset window.
  assign bus.cmd_ready = rst & (state == IDLE);
  assign bus.wd_ready  = (state == WR);
  assign bus.rd_valid  = (state == RD_OUT);
  assign bus.rd_last   = (state == RD_OUT) && (cnt == '0);
  assign bus.rd_data   = rd_data_q;
  assign bus.mem_valid = wr_pulse_q | (state == RD_REQ) | (state == RD_CAP);
  assign bus.mem_wr_rd = wr_pulse_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
endmodule

// File: doc/ram_master.md
RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 SHALL have parameter N, default 4, address width in bits.
REQ-002 SHALL have parameter D, default 16, memory depth in words (D = 2^N).
REQ-003 SHALL have parameter W, default 8, data width in bits.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-008 cmd_wr  input  1  1 = write burst, 0 = read burst.
REQ-009 cmd_addr  input  N  burst start address.
REQ-010 cmd_len  input  N  burst length minus 1 (1..D beats).
REQ-011 wd_valid  input  1  write beat data offered.
REQ-012 wd_ready  output  1  write beat accepted on wd_valid and wd_ready.
REQ-013 wd_data  input  W  write beat data.
REQ-014 rd_valid  output  1  read beat data available.
REQ-015 rd_ready  input  1  read beat consumed on rd_valid and rd_ready.
REQ-016 rd_data  output  W  read beat data.
REQ-017 rd_last  output  1  marks final read beat of burst.
REQ-018 mem_valid  output  1  RAM request strobe.
REQ-019 mem_wr_rd  output  1  RAM direction, 1 = write.
REQ-020 mem_addr  output  N  RAM address.
REQ-021 mem_wdata  output  W  RAM write data.
REQ-022 mem_rdata  input  W  RAM read data.
REQ-023 mem_ready  input  1  RAM read-data-valid indication.
REQ-024 busy  output  1  high whenever state is not IDLE.
REQ-025 done  output  1  one-cycle pulse at burst completion.

Function
REQ-026 SHALL implement states IDLE, WR, RD_REQ, RD_CAP, RD_OUT.
REQ-027 cmd_ready SHALL equal 1 only in IDLE; on acceptance: latch addr, beat count = cmd_len; go to WR if cmd_wr, else RD_REQ.
REQ-028 WR: wd_ready = 1; each handshake registers mem_valid=1, mem_wr_rd=1, mem_addr=current addr, mem_wdata=wd_data for exactly the next cycle.
REQ-029 mem_valid SHALL be 0 in any cycle following a WR cycle without a handshake (gaps produce no RAM write).
REQ-030 Write throughput SHALL be one beat per cycle.
REQ-031 After the last write handshake, state SHALL go to IDLE; done SHALL be high in the same cycle as the last mem_valid pulse.
REQ-032 RD_REQ: mem_valid=1, mem_wr_rd=0, mem_addr=current addr; next state RD_CAP.
REQ-033 RD_CAP: mem_valid and mem_addr held; when mem_ready=1, latch mem_rdata into rd_data and go RD_OUT; otherwise stay in RD_CAP.
REQ-034 RD_OUT: mem_valid=0, rd_valid=1, rd_data stable, rd_last=1 iff beat count is 0; held until rd_ready.
REQ-035 On RD_OUT handshake: if last, go to IDLE with done=1 for one cycle; else advance addr and go to RD_REQ.
REQ-036 Address SHALL advance by 1 per beat modulo D (D-1 wraps to 0); beat count decrements by 1 per beat.
REQ-037 wd_ready SHALL be 0 outside WR; rd_valid and rd_last SHALL be 0 outside RD_OUT.
REQ-038 mem_wr_rd SHALL be 0 whenever mem_valid is 0.
REQ-039 cmd_valid while busy SHALL be ignored; cmd_len = D-1 SHALL produce D beats covering every address once.

Reset
REQ-040 rst=0 at a rising edge SHALL force IDLE and clear addr, beat count, rd_data, mem_addr, and mem_wdata to 0, regardless of state.
REQ-041 During and after reset, every output SHALL be 0 except cmd_ready, which SHALL be 1 from the first cycle after rst returns to 1.
REQ-042 Reset mid-burst SHALL abort the burst: no further mem_valid, no done pulse, and remaining beats discarded.

Verification
REQ-043 Hold rst=0 for 2 cycles, then release -> all outputs 0 during reset; cmd_ready=1, busy=0 afterwards.
REQ-044 Write addr 3, len 0, data 0xA5, then read addr 3, len 0 -> one mem_valid write pulse at addr 3; rd_data=0xA5, rd_last=1, one done pulse per burst.
REQ-045 Write addr 14, len 3, data 1,2,3,4 -> mem_addr 14,15,0,1 on 4 consecutive pulses; read back -> 1,2,3,4 with rd_last only on the 4th beat.
REQ-046 Read burst with rd_ready low for 5 cycles -> rd_valid and rd_data stable, mem_valid=0, and addr unchanged throughout.
REQ-047 Write burst len 2 with wd_valid low for 2 cycles between beats -> exactly 3 mem_valid pulses and no pulse in the gap cycles.
REQ-048 Assert rst=0 during RD_CAP of beat 2 of 4 -> outputs 0 next cycle, no done, and cmd_ready=1 after release.
